mdom_wvb_hdr_gen: RTL

Waveform-buffer header generator for one mDOM ADC channel. It watches the trigger stream and the waveform buffer write pointer, timestamps each event with the local time counter (LTC), and tracks the event's start and stop buffer addresses. It packs these fields with the trigger metadata into the 80-bit waveform header bundle and pushes one bundle per event into the header FIFO. Downstream readout unpacks the same bundle layout.

---
 rtl/mdom_wvb_hdr_gen_if.sv | 30 +++
 rtl/mdom_wvb_hdr_gen.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mdom_wvb_hdr_gen_if.sv
// Trigger/config stream and header-FIFO side of the mDOM waveform header generator.
interface mdom_wvb_hdr_gen_if #(
  parameter int P_ADR_W  = 12,
  parameter int P_OVFL_W = 16
);
  logic                en;
  logic                trig;
  logic [1:0]          trig_src;
  logic                cnst_run;
  logic [4:0]          pre_conf;
  logic [11:0]         post_conf;
  logic [47:0]         ltc;
  logic [P_ADR_W-1:0]  wvb_wr_addr;
  logic                hdr_full;
  logic [79:0]         hdr_bundle;
  logic                hdr_wr;
  logic                busy;
  logic                hdr_ovfl;
  logic [P_OVFL_W-1:0] ovfl_cnt;

  modport master (
    output en, trig, trig_src, cnst_run, pre_conf, post_conf, ltc, wvb_wr_addr, hdr_full,
    input  hdr_bundle, hdr_wr, busy, hdr_ovfl, ovfl_cnt
  );

  modport slave (
    input  en, trig, trig_src, cnst_run, pre_conf, post_conf, ltc, wvb_wr_addr, hdr_full,
    output hdr_bundle, hdr_wr, busy, hdr_ovfl, ovfl_cnt
  );
endinterface

// File: rtl/mdom_wvb_hdr_gen.sv
// Waveform-buffer header generator: timestamps each trigger, tracks start/stop buffer
// addresses and pushes one packed 80-bit header per event into the header FIFO.
module mdom_wvb_hdr_gen #(
  parameter int P_ADR_W  = 12,
  parameter int P_OVFL_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  mdom_wvb_hdr_gen_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_POST = 2'd1,
    S_CNST = 2'd2,
    S_PUSH = 2'd3
  } state_t;

  localparam logic [P_ADR_W-1:0] ADR_ONE  = {{(P_ADR_W-1){1'b0}}, 1'b1};
  localparam logic [11:0]        POST_ONE = 12'd1;

  state_t state, state_nxt;

  logic                trig_acc;
  logic [P_ADR_W-1:0]  start_now;
  logic                push_go;
  logic [P_ADR_W-1:0]  stop_nxt;

  // Event fields latched at the trigger cycle
  logic [47:0]         evt_ltc;
  logic [P_ADR_W-1:0]  evt_start;
  logic [P_ADR_W-1:0]  evt_guard;
  logic [1:0]          evt_src;
  logic                evt_cnst;
  logic [4:0]          evt_pre;
  logic [11:0]         post_cnt;

  // Field sources for the header being packed this cycle
  logic [47:0]         f_ltc;
  logic [P_ADR_W-1:0]  f_start;
  logic [1:0]          f_src;
  logic                f_cnst;
  logic [4:0]          f_pre;

  logic [79:0]         hdr_bundle_q;
  logic                hdr_wr_q;
  logic                busy_q;
  logic                hdr_ovfl_q;
  logic [P_OVFL_W-1:0] ovfl_cnt_q;

  function automatic logic [P_OVFL_W-1:0] sat_inc(input logic [P_OVFL_W-1:0] v);
    return (&v) ? v : v + {{(P_OVFL_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [79:0] pack_bundle(
    input logic [47:0]        t,
    input logic [P_ADR_W-1:0] s,
    input logic [P_ADR_W-1:0] e,
    input logic [1:0]         src,
    input logic               cr,
    input logic [4:0]         pre
  );
    return {pre, cr, src, 12'(e), 12'(s), t};
  endfunction

  assign trig_acc  = (state == S_IDLE) && bus.en && bus.trig;
  assign start_now = bus.wvb_wr_addr - P_ADR_W'(bus.pre_conf);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // The wrap guard fires only when the normal end has not already been reached this cycle.
  always_comb begin
    state_nxt = state;
    push_go   = 1'b0;
    stop_nxt  = bus.wvb_wr_addr;
    case (state)
      S_IDLE: begin
        if (trig_acc) begin
          if (bus.cnst_run) begin
            state_nxt = S_CNST;
          end else if (bus.post_conf == '0) begin
            state_nxt = S_PUSH;
            push_go   = 1'b1;
          end else begin
            state_nxt = S_POST;
          end
        end
      end
      S_POST: begin
        if ((post_cnt == POST_ONE) || (bus.wvb_wr_addr == evt_guard)) begin
          state_nxt = S_PUSH;
          push_go   = 1'b1;
        end
      end
      S_CNST: begin
        if (!bus.trig) begin
          state_nxt = S_PUSH;
          push_go   = 1'b1;
          stop_nxt  = bus.wvb_wr_addr - ADR_ONE;
        end else if (bus.wvb_wr_addr == evt_guard) begin
          state_nxt = S_PUSH;
          push_go   = 1'b1;
        end
      end
      S_PUSH: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // A zero post-trigger event is packed straight from the live inputs at the trigger cycle.
  always_comb begin
    f_ltc   = evt_ltc;
    f_start = evt_start;
    f_src   = evt_src;
    f_cnst  = evt_cnst;
    f_pre   = evt_pre;
    if (state == S_IDLE) begin
      f_ltc   = bus.ltc;
      f_start = start_now;
      f_src   = bus.trig_src;
      f_cnst  = bus.cnst_run;
      f_pre   = bus.pre_conf;
    end
  end

  always_ff @(posedge clk) begin
    if (trig_acc) begin
      evt_ltc   <= bus.ltc;
      evt_start <= start_now;
      evt_guard <= start_now - ADR_ONE;
      evt_src   <= bus.trig_src;
      evt_cnst  <= bus.cnst_run;
      evt_pre   <= bus.pre_conf;
      post_cnt  <= bus.post_conf;
    end else if (state == S_POST) begin
      post_cnt  <= post_cnt - POST_ONE;
    end
  end

  // Registered outputs: the push decision is taken on the edge that enters S_PUSH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_bundle_q <= '0;
      hdr_wr_q     <= 1'b0;
      busy_q       <= 1'b0;
      hdr_ovfl_q   <= 1'b0;
      ovfl_cnt_q   <= '0;
    end else begin
      busy_q     <= (state_nxt != S_IDLE);
      hdr_wr_q   <= push_go && !bus.hdr_full;
      hdr_ovfl_q <= push_go && bus.hdr_full;
      if (push_go) begin
        hdr_bundle_q <= pack_bundle(f_ltc, f_start, stop_nxt, f_src, f_cnst, f_pre);
      end
      if (push_go && bus.hdr_full) begin
        ovfl_cnt_q <= sat_inc(ovfl_cnt_q);
      end
    end
  end

  assign bus.hdr_bundle = hdr_bundle_q;
  assign bus.hdr_wr     = hdr_wr_q;
  assign bus.busy       = busy_q;
  assign bus.hdr_ovfl   = hdr_ovfl_q;
  assign bus.ovfl_cnt   = ovfl_cnt_q;

endmodule
